// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and streams
// {instr, addr, err} through a 2-entry valid/ready buffer for instruction-memory writes.
module instr_encoder #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_seen
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic signed [31:0] imm_s;
    logic [31:0]        enc_instr;
    logic               enc_err;

    assign imm_s = in_imm;

    always_comb begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
        case (fmt_e'(in_fmt))
            FMT_R: begin
                enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = 1'b0;
            end
            FMT_I: begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            FMT_S: begin
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            FMT_B: begin
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            end
            FMT_U: begin
                enc_instr = {in_imm[31:12], in_rd, in_opcode};
                enc_err   = |in_imm[11:0];
            end
            FMT_J: begin
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            end
            default: begin
                enc_instr = 32'h0000_0013;
                enc_err   = 1'b1;
            end
        endcase
    end

    logic [31:0]       instr_q [2];
    logic [ADDR_W-1:0] addr_q  [2];
    logic              err_q   [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2) & ~clear;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry drives the outputs directly, so reset values appear as soon as rst_n falls.
    assign out_instr = instr_q[rd_ptr];
    assign out_addr  = addr_q[rd_ptr];
    assign out_err   = err_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                addr_q[i]  <= BASE_ADDR;
                err_q[i]   <= 1'b0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err_seen <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err_seen <= 1'b0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= enc_instr;
                addr_q[wr_ptr]  <= addr_cnt;
                err_q[wr_ptr]   <= enc_err;
                wr_ptr          <= ~wr_ptr;
                addr_cnt        <= addr_cnt + ADDR_W'(4);
                err_seen        <= err_seen | enc_err;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random and directed field streams are checked
// against a field-level packing model and an immext round-trip decode.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [3:0]  out_addr;
    logic        out_err;
    logic        err_seen;

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  addr;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        has_gold;
        logic [31:0] gold;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rt_n = 0;
    int unsigned m_addr = 0;
    logic        m_seen = 1'b0;
    logic        g_has = 1'b0;
    logic [31:0] g_instr = '0;
    logic        rand_ready = 1'b0;
    logic        ready_cmd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing built from the field layout with shifts and masks.
    function automatic void model(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm,
                                  output logic [31:0] ins, output logic err);
        int          s;
        logic [31:0] b;
        s = $signed(imm);
        b = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            3'd0: begin
                ins = (32'(f7) << 25) | (32'(rs2) << 20) | b | (32'(rd) << 7);
                err = 1'b0;
            end
            3'd1: begin
                ins = ((imm & 32'hFFF) << 20) | b | (32'(rd) << 7);
                err = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                ins = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | b | ((imm & 32'h1F) << 7);
                err = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                ins = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                      (32'(rs2) << 20) | b | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                err = (s < -4096) || (s > 4094) || ((s % 2) != 0);
            end
            3'd4: begin
                ins = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                err = (imm & 32'hFFF) != 0;
            end
            3'd5: begin
                ins = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                      (32'(rd) << 7) | 32'(op);
                err = (s < -1048576) || (s > 1048574) || ((s % 2) != 0);
            end
            default: begin
                ins = 32'h0000_0013;
                err = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [31:0] immext(input logic [31:0] i, input logic [2:0] fmt);
        case (fmt)
            3'd1:    return {{20{i[31]}}, i[31:20]};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    // Monitor and scoreboard; handshakes are sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ins;
        logic        err;
        if (!rst_n) begin
            sb.delete();
            m_addr = 0;
            m_seen = 1'b0;
        end else begin
            check("err_seen", 32'(err_seen), 32'(m_seen));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("instr", out_instr, e.instr);
                    check("addr", 32'(out_addr), 32'(e.addr));
                    check("err", 32'(out_err), 32'(e.err));
                    if (e.has_gold) check("golden", out_instr, e.gold);
                    if (!e.err && (e.fmt inside {3'd1, 3'd2, 3'd3, 3'd5})) begin
                        rt_n++;
                        check("roundtrip", immext(out_instr, e.fmt), e.imm);
                    end
                end
            end
            if (clear) begin
                sb.delete();
                m_addr = 0;
                m_seen = 1'b0;
            end else if (in_valid && in_ready) begin
                model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ins, err);
                e.instr = ins; e.addr = m_addr[3:0]; e.err = err; e.fmt = in_fmt;
                e.imm = in_imm; e.has_gold = g_has; e.gold = g_instr;
                sb.push_back(e);
                m_addr = (m_addr + 4) % 16;
                if (err) m_seen = 1'b1;
            end
        end
    end

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        logic acc;
        set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        g_has = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_gold(input logic [31:0] gold, input logic [2:0] fmt, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] f3, input logic [31:0] imm);
        g_has = 1'b1;
        g_instr = gold;
        send(fmt, op, rd, rs1, rs2, f3, 7'd0, imm);
    endtask

    task automatic drain();
        ready_cmd = 1'b1;
        for (int t = 0; t < 500 && (sb.size() != 0 || out_valid); t++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] imm;
        int          r;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_seen", 32'(err_seen), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;

        // Golden words; five accepts also walk the 4-bit address through its wrap.
        send_gold(32'hFFF0_0093, 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        send_gold(32'h0020_2423, 3'd2, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'd2, 32'd8);
        send_gold(32'hFE00_0EE3, 3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        send_gold(32'h0010_00EF, 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        send_gold(32'h1234_52B7, 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        drain();
        check("no_err_seen", 32'(err_seen), 32'd0);

        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        drain();
        check("err_seen_set", 32'(err_seen), 32'd1);
        send(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_gold(32'h0000_0013, 3'd7, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd1, 32'd0);
        drain();

        pulse_clear();
        check("clear_err_seen", 32'(err_seen), 32'd0);
        check("clear_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: two entries fill the buffer, the third must stall.
        ready_cmd = 1'b0;
        @(posedge clk);
        #1;
        send(3'd1, 7'b0010011, 5'd10, 5'd11, 5'd0, 3'd0, 7'd0, 32'd100);
        send(3'd2, 7'b0100011, 5'd0, 5'd12, 5'd13, 3'd2, 7'd0, 32'hFFFF_FF00);
        set_fields(3'd3, 7'b1100011, 5'd0, 5'd14, 5'd15, 3'd1, 7'd0, 32'd64);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_out_valid", 32'(out_valid), 32'd1);
            if (sb.size() != 0) check("full_head_hold", out_instr, sb[0].instr);
        end
        ready_cmd = 1'b1;
        send(3'd3, 7'b1100011, 5'd0, 5'd14, 5'd15, 3'd1, 7'd0, 32'd64);
        drain();

        // Asynchronous reset with two entries buffered.
        ready_cmd = 1'b0;
        @(posedge clk);
        #1;
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_addr", 32'(out_addr), 32'd0);
        check("async_rst_instr", out_instr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        drain();

        // Random stream, mostly legal I/S/B/J so the round trip is well exercised.
        rand_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 19);
            if (r < 16) f = (r % 4 == 3) ? 3'd5 : 3'(r % 4 + 1);
            else if (r == 16) f = 3'd0;
            else if (r == 17) f = 3'd4;
            else f = 3'($urandom_range(6, 7));
            case (f)
                3'd1, 3'd2: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                3'd3:       imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                3'd5:       imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                3'd4:       imm = $urandom & 32'hFFFF_F000;
                default:    imm = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) imm = $urandom;
            if ($urandom_range(0, 199) == 0) pulse_clear();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm);
        end
        rand_ready = 1'b0;
        drain();
        check("roundtrip_count", 32'(rt_n >= 1000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RISC-V RV32I instruction encoder. It takes decoded fields (format, opcode, registers, functs, 32-bit immediate) and packs them into a 32-bit instruction word, scattering immediate bits in the exact inverse of the immext decoding. It is used by the instruction-memory loader/self-test path to build instruction words on chip. Output goes through a 2-entry buffer with a valid/ready handshake, paired with an incrementing word address for instruction-memory writes.

Parameters:
ADDR_W, 32, width of out_addr and the address counter
BASE_ADDR, 0, value loaded into the address counter at reset and on clear

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  sync: reload address counter, flush buffer, clear err_seen
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept
in_fmt  input  3  0=R,1=I,2=S,3=B,4=U,5=J,6/7 illegal
in_opcode  input  7  opcode[6:0]
in_rd  input  5  rd
in_rs1  input  5  rs1
in_rs2  input  5  rs2
in_funct3  input  3  funct3
in_funct7  input  7  funct7
in_imm  input  32  signed byte-offset/immediate (U: full 32-bit value)
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  address of out_instr
out_err  output  1  head entry had range/alignment/format error
err_seen  output  1  sticky OR of all accepted errors

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_seen=0, address counter=BASE_ADDR. Outputs hold these values while rst_n=0. Deassertion takes effect at the next edge.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready. in_ready = (entries<2) & ~clear. Not combinationally dependent on out_ready.
- Latency: an entry accepted at edge N shows out_valid=1 at N+1 when the buffer was empty. Order is FIFO. Push and pop in the same cycle leaves the count unchanged.
- Each accept captures {instr, addr_counter, err}. The counter then advances by 4 and wraps modulo 2^ADDR_W.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode; imm ignored.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Error checks (the word is still emitted, with truncated bits):
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0] != 0.
  - fmt 6/7: out_instr=32'h0000_0013 (nop).
- err_seen is set on acceptance of an erroring entry and cleared only by reset or clear.
- clear=1: buffer emptied, out_valid=0 next cycle, counter=BASE_ADDR, err_seen=0. No accept occurs that cycle.
- Full (2 entries) with out_ready=0: in_ready=0 and the head entry holds stable.
- Invariant: feeding out_instr back through immext reproduces in_imm for every error-free B/J/I/S input.

Test Plan:
- I/S/B/J/U golden words:
  - I: fmt=I, op=0010011, rd=1, rs1=0, f3=0, imm=-1 -> out_instr=0xFFF00093, addr=0, err=0.
  - S: fmt=S, op=0100011, rs1=0, rs2=2, f3=2, imm=8 -> 0x00202423, addr=4.
  - B: fmt=B, op=1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
  - J: fmt=J, op=1101111, rd=1, imm=2048 -> 0x001000EF.
  - U: fmt=U, op=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors: B imm=3 -> err=1 and err_seen=1. I imm=2048 -> err=1. fmt=7 -> out_instr=0x00000013, err=1. clear -> err_seen=0, next addr=BASE_ADDR.
- Backpressure: out_ready=0 while sending 3 words -> in_ready=0 after 2 accepts. Release out_ready -> words drain in order with addrs 0, 4, 8.
- Address wrap: ADDR_W=4, 5 accepts -> out_addr sequence 0, 4, 8, 12, 0.
- Reset mid-stream: rst_n=0 asynchronously with 2 entries buffered -> out_valid=0 immediately, and the first word after release has addr=BASE_ADDR.
- Round trip: 1000 random legal I/S/B/J inputs through the encoder, then into immext -> every immediate matches.
